// File: rtl/serial_frame_scheduler.sv
// Serial frame scheduler.
// Four sources compete for one serial line, and a round-robin arbiter picks the winner.
// The winner's descriptor is latched and sent as a frame: start bit, port, len, then len data bits.
// The block then waits for the downstream Done (or a timeout) before it can grant again.
module serial_frame_scheduler (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic [3:0]  req,
  input  logic [83:0] desc,
  input  logic        Done,
  output logic        SerOut,
  output logic [3:0]  gnt,
  output logic [3:0]  ack,
  output logic        err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_DATA, S_WAIT} state_t;

  localparam logic [4:0] WAIT_LAST = 5'd30;

  state_t      stateQ, stateD;
  logic [4:0]  cntQ, cntD;
  logic        serQ, serD;
  logic [3:0]  gntQ, gntD;
  logic [3:0]  ackQ, ackD;
  logic        errQ, errD;
  logic [1:0]  ptrQ, ptrD;
  logic [1:0]  ownQ, ownD;
  logic [20:0] descQ, descD;

  logic [20:0] descArr [4];
  logic [1:0]  winIdx;
  logic [1:0]  cand;
  logic        winFound;

  logic [1:0]  portF;
  logic [3:0]  lenF;
  logic [14:0] dataF;
  logic [5:0]  hdrBits;
  logic [2:0]  hdrIdx;
  logic [3:0]  dataIdx;

  assign {portF, lenF, dataF} = descQ;
  assign hdrBits = {portF, lenF};
  assign hdrIdx  = 3'd5 - cntQ[2:0];
  assign dataIdx = cntQ[3:0] - 4'd1;

  assign SerOut = serQ;
  assign gnt    = gntQ;
  assign ack    = ackQ;
  assign err    = errQ;
  assign busy   = (stateQ != S_IDLE);

  // Split the flat descriptor bus into one 21-bit word per source.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      descArr[i] = desc[21*i +: 21];
    end
  end

  // Round-robin search: the first requester at or after the pointer, ascending modulo 4.
  always_comb begin
    winIdx   = ptrQ;
    winFound = 1'b0;
    cand     = ptrQ;
    for (int k = 0; k < 4; k++) begin
      cand = ptrQ + k[1:0];
      if (!winFound && req[cand]) begin
        winIdx   = cand;
        winFound = 1'b1;
      end
    end
  end

  // Frame sequencing: cntQ is the header index, the remaining data-bit count, or the WAIT timer.
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    serD   = serQ;
    gntD   = gntQ;
    ackD   = 4'd0;
    errD   = 1'b0;
    ptrD   = ptrQ;
    ownD   = ownQ;
    descD  = descQ;
    case (stateQ)
      S_IDLE: begin
        if (clkEn && winFound) begin
          gntD   = 4'b0001 << winIdx;
          ownD   = winIdx;
          descD  = descArr[winIdx];
          serD   = 1'b0;
          cntD   = 5'd0;
          stateD = S_HDR;
        end
      end
      S_HDR: begin
        if (clkEn) begin
          if (cntQ == 5'd6) begin
            serD   = 1'b1;
            cntD   = 5'd0;
            stateD = S_WAIT;
          end else begin
            serD = hdrBits[hdrIdx];
            if (cntQ == 5'd5 && lenF != 4'd0) begin
              cntD   = {1'b0, lenF};
              stateD = S_DATA;
            end else begin
              cntD = cntQ + 5'd1;
            end
          end
        end
      end
      S_DATA: begin
        if (clkEn) begin
          if (cntQ == 5'd0) begin
            serD   = 1'b1;
            stateD = S_WAIT;
          end else begin
            serD = dataF[dataIdx];
            cntD = cntQ - 5'd1;
          end
        end
      end
      S_WAIT: begin
        if (Done) begin
          ackD   = gntQ;
          gntD   = 4'd0;
          ptrD   = ownQ + 2'd1;
          cntD   = 5'd0;
          stateD = S_IDLE;
        end else if (clkEn) begin
          if (cntQ == WAIT_LAST) begin
            errD   = 1'b1;
            gntD   = 4'd0;
            ptrD   = ownQ + 2'd1;
            cntD   = 5'd0;
            stateD = S_IDLE;
          end else begin
            cntD = cntQ + 5'd1;
          end
        end
      end
      default: begin
        stateD = S_IDLE;
      end
    endcase
  end

  // State register. Reset wins over clkEn and returns the line to idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ <= S_IDLE;
      cntQ   <= 5'd0;
      serQ   <= 1'b1;
      gntQ   <= 4'd0;
      ackQ   <= 4'd0;
      errQ   <= 1'b0;
      ptrQ   <= 2'd0;
      ownQ   <= 2'd0;
      descQ  <= 21'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      serQ   <= serD;
      gntQ   <= gntD;
      ackQ   <= ackD;
      errQ   <= errD;
      ptrQ   <= ptrD;
      ownQ   <= ownD;
      descQ  <= descD;
    end
  end

endmodule

// File: tb/tb_serial_frame_scheduler.sv
// Directed bench for serial_frame_scheduler.
// A table of frames is followed by hand-written timeout, reset and slow-enable sequences.
module tb_serial_frame_scheduler;

  localparam logic [20:0] JUNK = 21'h1FFFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        clkEn;
  logic [3:0]  req;
  logic [83:0] desc;
  logic        Done;
  logic        SerOut;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        err;
  logic        busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  req;
    logic [1:0]  port;
    logic [3:0]  len;
    logic [14:0] data;
    logic [3:0]  expGnt;
  } vec_t;

  vec_t vecs [8];

  serial_frame_scheduler dut (
    .clk    (clk),
    .rst    (rst),
    .clkEn  (clkEn),
    .req    (req),
    .desc   (desc),
    .Done   (Done),
    .SerOut (SerOut),
    .gnt    (gnt),
    .ack    (ack),
    .err    (err),
    .busy   (busy)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Drive the request vector, with junk in every descriptor slot except the winner's.
  task automatic applyStimulus(input logic [3:0] r, input int slot, input logic [20:0] d);
    req = r;
    desc = {4{JUNK}};
    desc[21*slot +: 21] = d;
  endtask

  function automatic int oneHotIdx(input logic [3:0] g);
    int idx = 0;
    for (int i = 0; i < 4; i++) if (g[i]) idx = i;
    return idx;
  endfunction

  // Send one complete frame at full rate, then return Done after doneDelay WAIT cycles.
  task automatic runFrame(input logic [3:0] r, input logic [1:0] port, input logic [3:0] len,
                          input logic [14:0] data, input logic [3:0] expGnt, input int doneDelay,
                          output logic [31:0] lowBits);
    int n;
    logic [31:0] expBits;
    logic gntOk;
    n = 7 + int'(len);
    expBits = 32'd0;
    expBits = {expBits[30:0], 1'b0};
    expBits = {expBits[30:0], port[1]};
    expBits = {expBits[30:0], port[0]};
    for (int i = 3; i >= 0; i--) expBits = {expBits[30:0], len[i]};
    for (int i = int'(len) - 1; i >= 0; i--) expBits = {expBits[30:0], data[i]};
    applyStimulus(r, oneHotIdx(expGnt), {port, len, data});
    clkEn = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("grant", {28'd0, gnt}, {28'd0, expGnt});
    checkOutput("ackAtGrant", {28'd0, ack}, 32'd0);
    desc = {4{JUNK}};
    lowBits = {31'd0, SerOut};
    gntOk = (gnt === expGnt) && (busy === 1'b1);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); @(negedge clk);
      lowBits = {lowBits[30:0], SerOut};
      if (gnt !== expGnt || busy !== 1'b1) gntOk = 1'b0;
    end
    checkOutput("frameBits", lowBits, expBits);
    checkOutput("gntHeld", {31'd0, gntOk}, 32'd1);
    @(posedge clk); @(negedge clk);
    checkOutput("lineIdleInWait", {31'd0, SerOut}, 32'd1);
    repeat (doneDelay) begin
      @(posedge clk); @(negedge clk);
    end
    checkOutput("busyInWait", {31'd0, busy}, 32'd1);
    Done = 1'b1;
    @(posedge clk); @(negedge clk);
    Done = 1'b0;
    checkOutput("ackPulse", {28'd0, ack}, {28'd0, expGnt});
    checkOutput("gntCleared", {28'd0, gnt}, 32'd0);
    checkOutput("busyIdle", {31'd0, busy}, 32'd0);
    checkOutput("noErr", {31'd0, err}, 32'd0);
  endtask

  initial begin
    logic [31:0] bits;
    logic bitsOk, ackSeen, stray;
    logic [8:0] slowExp;
    int k;

    // Pointer walk: reset p=0, and each frame moves p to the winner plus one.
    vecs[0] = '{4'b0001, 2'b10, 4'd3,  15'b101,    4'b0001};
    vecs[1] = '{4'b1111, 2'b01, 4'd5,  15'h001A,   4'b0010};
    vecs[2] = '{4'b1111, 2'b00, 4'd15, 15'h2A5C,   4'b0100};
    vecs[3] = '{4'b1111, 2'b11, 4'd1,  15'h7FFE,   4'b1000};
    vecs[4] = '{4'b1111, 2'b11, 4'd0,  15'h7FFF,   4'b0001};
    vecs[5] = '{4'b0001, 2'b00, 4'd2,  15'b10,     4'b0001};
    vecs[6] = '{4'b1001, 2'b10, 4'd4,  15'h0009,   4'b1000};
    vecs[7] = '{4'b0110, 2'b01, 4'd6,  15'h0035,   4'b0010};

    rst = 1'b1; clkEn = 1'b0; req = 4'd0; desc = 84'd0; Done = 1'b0;
    @(negedge clk);
    checkOutput("rstSerOut", {31'd0, SerOut}, 32'd1);
    checkOutput("rstGnt", {28'd0, gnt}, 32'd0);
    checkOutput("rstAck", {28'd0, ack}, 32'd0);
    checkOutput("rstErr", {31'd0, err}, 32'd0);
    checkOutput("rstBusy", {31'd0, busy}, 32'd0);
    rst = 1'b0;

    for (int v = 0; v < 8; v++) begin
      runFrame(vecs[v].req, vecs[v].port, vecs[v].len, vecs[v].data, vecs[v].expGnt, 3, bits);
      if (v == 0) checkOutput("literalFrame3", bits, 32'b0100011101);
      if (v == 4) checkOutput("literalFrameLen0", bits, 32'b0110000);
    end

    // Timeout: p=2, so source 2 wins, sends 8 low-phase bits, and Done never arrives.
    applyStimulus(4'b1100, 2, {2'd1, 4'd1, 15'h0001});
    @(posedge clk); @(negedge clk);
    checkOutput("toGrant", {28'd0, gnt}, 32'b0100);
    repeat (8) begin
      @(posedge clk); @(negedge clk);
    end
    checkOutput("toWaitLine", {31'd0, SerOut}, 32'd1);
    k = 0;
    stray = 1'b0;
    while (err !== 1'b1 && k < 40) begin
      @(posedge clk); @(negedge clk);
      k++;
      if (ack !== 4'd0) stray = 1'b1;
    end
    checkOutput("timeoutCycles", k, 31);
    checkOutput("timeoutNoAck", {31'd0, stray}, 32'd0);
    checkOutput("timeoutGnt", {28'd0, gnt}, 32'd0);
    // The next grant goes to the following source (3), whose 8-bit frame is cut by reset in DATA.
    applyStimulus(4'b1100, 3, {2'd0, 4'd8, 15'h00FF});
    @(posedge clk); @(negedge clk);
    checkOutput("afterTimeoutGrant", {28'd0, gnt}, 32'b1000);
    repeat (7) begin
      @(posedge clk); @(negedge clk);
    end
    checkOutput("midDataBusy", {31'd0, busy}, 32'd1);
    rst = 1'b1; clkEn = 1'b0; req = 4'd0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    checkOutput("midRstSerOut", {31'd0, SerOut}, 32'd1);
    checkOutput("midRstGnt", {28'd0, gnt}, 32'd0);
    checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
    // Reset moved p from 3 to 0, so source 1 beats source 3.
    runFrame(4'b1010, 2'b01, 4'd2, 15'b11, 4'b0010, 1, bits);

    // Slow line: one enable every 4 clocks, and req drops after the grant.
    // A stray Done during the header must be ignored.
    slowExp = 9'b010001001;
    applyStimulus(4'b0100, 2, {2'd2, 4'd2, 15'd1});
    clkEn = 1'b1;
    @(posedge clk); @(negedge clk);
    checkOutput("slowGrant", {28'd0, gnt}, 32'b0100);
    req = 4'd0;
    desc = {4{JUNK}};
    bitsOk = 1'b1;
    ackSeen = 1'b0;
    for (int s = 0; s < 36; s++) begin
      if (SerOut !== slowExp[8 - s/4]) bitsOk = 1'b0;
      if (ack !== 4'd0) ackSeen = 1'b1;
      clkEn = ((s % 4) == 3);
      Done = (s == 10);
      @(posedge clk); @(negedge clk);
    end
    checkOutput("slowBits", {31'd0, bitsOk}, 32'd1);
    checkOutput("strayDoneIgnored", {31'd0, ackSeen}, 32'd0);
    checkOutput("slowWaitLine", {31'd0, SerOut}, 32'd1);
    clkEn = 1'b0;
    Done = 1'b1;
    @(posedge clk); @(negedge clk);
    Done = 1'b0;
    checkOutput("slowAck", {28'd0, ack}, 32'b0100);
    checkOutput("slowBusy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(negedge clk);
    checkOutput("ackOneClk", {28'd0, ack}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
